// File: rtl/line_pattern_writer.sv
// Writer side of the two-bank line buffer: on start, streams one row pair of
// test-pattern pixels into the selected bank, one pixel per clock.
module line_pattern_writer #(
    parameter int x_count       = 64,
    parameter int y_width       = 5,
    parameter int color_width   = 8,
    parameter int address_width = 7
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [y_width-1:0]         y,
    input  logic                       bank,
    input  logic [1:0]                 pattern_select,
    input  logic [9:0]                 frame_count,
    output logic                       is_idle,
    output logic [address_width-1:0]  write_address,
    output logic [6*color_width-1:0]   write_data,
    output logic                       write_enable
);

    localparam int x_width     = $clog2(x_count);
    localparam int pixel_width = 3 * color_width;

    typedef enum logic [1:0] {
        kIdle  = 2'd0,
        kWrite = 2'd1,
        kDrain = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [x_width-1:0]           x_q, x_d;
    logic [y_width-1:0]           y_q, y_d;
    logic                         bank_q, bank_d;
    logic [1:0]                   pattern_q, pattern_d;
    logic [9:0]                   frame_q, frame_d;
    logic                         is_idle_q, is_idle_d;
    logic [address_width-1:0]     write_address_q, write_address_d;
    logic [6*color_width-1:0]     write_data_q, write_data_d;
    logic                         write_enable_q, write_enable_d;

    // One pixel {r,g,b} for column px of panel row `row` (row carries the half bit).
    function automatic logic [pixel_width-1:0] pixel(
        input logic [1:0]         pat,
        input logic [x_width-1:0] px,
        input logic [y_width:0]   row,
        input logic [9:0]         fc
    );
        logic [color_width-1:0] ones, r, g, b;
        logic [x_width-1:0]     s;
        ones = '1;
        r    = '0;
        g    = '0;
        b    = '0;
        s    = px + x_width'(fc[5:0]);
        case (pat)
            2'd0: begin
                r = color_width'({px, 2'b00});
                g = color_width'({row, 2'b00});
                b = color_width'(fc[7:0]);
            end
            2'd1: begin
                r = ones;
                g = ones;
                b = ones;
            end
            2'd2: begin
                if ((px[0] ^ row[0]) == 1'b1) begin
                    r = ones;
                    g = ones;
                    b = ones;
                end else begin
                    r = '0;
                    g = '0;
                    b = '0;
                end
            end
            2'd3: begin
                // The top two bits of the scrolled column select a 16-wide colour bar.
                case (s[x_width-1 -: 2])
                    2'd0:    r = ones;
                    2'd1:    g = ones;
                    2'd2:    b = ones;
                    default: r = '0;
                endcase
            end
            default: r = '0;
        endcase
        return {r, g, b};
    endfunction

    // Job sequencing and the single output pipeline stage.
    always_comb begin
        state_d         = state_q;
        x_d             = x_q;
        y_d             = y_q;
        bank_d          = bank_q;
        pattern_d       = pattern_q;
        frame_d         = frame_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_data_d    = write_data_q;
        case (state_q)
            kIdle: begin
                if (start) begin
                    y_d       = y;
                    bank_d    = bank;
                    pattern_d = pattern_select;
                    frame_d   = frame_count;
                    x_d       = '0;
                    state_d   = kWrite;
                end else begin
                    state_d = kIdle;
                end
            end
            kWrite: begin
                write_enable_d  = 1'b1;
                write_address_d = address_width'({bank_q, x_q});
                write_data_d    = {pixel(pattern_q, x_q, {1'b1, y_q}, frame_q),
                                   pixel(pattern_q, x_q, {1'b0, y_q}, frame_q)};
                if (x_q == x_width'(x_count - 1)) begin
                    x_d     = '0;
                    state_d = kDrain;
                end else begin
                    x_d = x_q + x_width'(1);
                end
            end
            kDrain:  state_d = kIdle;
            default: state_d = kIdle;
        endcase
        is_idle_d = (state_d == kIdle);
    end

    // State, job and output registers; reset takes effect without a clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= kIdle;
            x_q             <= '0;
            y_q             <= '0;
            bank_q          <= 1'b0;
            pattern_q       <= 2'd0;
            frame_q         <= 10'd0;
            is_idle_q       <= 1'b1;
            write_address_q <= '0;
            write_data_q    <= '0;
            write_enable_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            x_q             <= x_d;
            y_q             <= y_d;
            bank_q          <= bank_d;
            pattern_q       <= pattern_d;
            frame_q         <= frame_d;
            is_idle_q       <= is_idle_d;
            write_address_q <= write_address_d;
            write_data_q    <= write_data_d;
            write_enable_q  <= write_enable_d;
        end
    end

    assign is_idle       = is_idle_q;
    assign write_address = write_address_q;
    assign write_data    = write_data_q;
    assign write_enable  = write_enable_q;

endmodule

// File: tb/tb_line_pattern_writer.sv
// Scoreboard bench for line_pattern_writer: stimulus queues expected writes,
// a negedge monitor pops and compares every presented write.
module tb_line_pattern_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  y = 5'd0;
    logic        bank = 1'b0;
    logic [1:0]  pattern_select = 2'd0;
    logic [9:0]  frame_count = 10'd0;
    logic        is_idle;
    logic [6:0]  write_address;
    logic [47:0] write_data;
    logic        write_enable;

    typedef struct packed {
        logic [6:0]  a;
        logic [47:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  writes_seen = 0;

    line_pattern_writer dut (
        .clock(clock), .reset(reset), .start(start), .y(y), .bank(bank),
        .pattern_select(pattern_select), .frame_count(frame_count),
        .is_idle(is_idle), .write_address(write_address),
        .write_data(write_data), .write_enable(write_enable)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference pixel from the pattern definitions, in integer arithmetic.
    function automatic logic [23:0] exp_pixel(input int pat, input int x, input int row, input int fc);
        int r, g, b, s;
        r = 0; g = 0; b = 0;
        case (pat)
            0: begin r = (x * 4) % 256; g = (row * 4) % 256; b = fc % 256; end
            1: begin r = 255; g = 255; b = 255; end
            2: if (((x + row) % 2) == 1) begin r = 255; g = 255; b = 255; end
            default: begin
                s = (x + (fc % 64)) % 64;
                if (s / 16 == 0) r = 255;
                else if (s / 16 == 1) g = 255;
                else if (s / 16 == 2) b = 255;
            end
        endcase
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && write_enable) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {57'd0, write_address}, 64'h7FFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_address", {57'd0, write_address}, {57'd0, e.a});
                check("write_data", {16'd0, write_data}, {16'd0, e.d});
            end
        end
    end

    // Issue one job from a negedge; hx1/hx2 select columns whose data is the hand value.
    task automatic run_job(input int ty, input int tb, input int tp, input int tf,
                           input int hx1, input logic [47:0] hd1,
                           input int hx2, input logic [47:0] hd2,
                           input bit perturb, input int rst_at);
        wr_t e;
        int  j, bad;
        for (int x = 0; x < 64; x++) begin
            e.a = 7'(tb * 64 + x);
            e.d = {exp_pixel(tp, x, 32 + ty, tf), exp_pixel(tp, x, ty, tf)};
            if (x == hx1) e.d = hd1;
            if (x == hx2) e.d = hd2;
            exp_q.push_back(e);
        end
        writes_seen = 0;
        y = 5'(ty); bank = tb[0]; pattern_select = 2'(tp); frame_count = 10'(tf);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", {63'd0, is_idle}, 64'd0);
        j = 0; bad = 0;
        while (j < 200) begin
            if (is_idle) break;
            if (write_enable !== ((j >= 1) && (j <= 64))) bad++;
            if (j == rst_at) begin
                reset = 1'b1;
                #1;
                check("reset_we", {63'd0, write_enable}, 64'd0);
                check("reset_idle", {63'd0, is_idle}, 64'd1);
                check("reset_addr", {57'd0, write_address}, 64'd0);
                exp_q.delete();
                @(negedge clock);
                reset = 1'b0;
                @(negedge clock);
                return;
            end
            if (perturb) begin
                start = (j == 4) || (j == 29);
                if (j == 2) y = 5'd7;
            end
            @(negedge clock);
            j++;
        end
        start = 1'b0;
        check("idle_return_cycle", 64'(j), 64'd65);
        check("we_window", 64'(bad), 64'd0);
        check("we_low_at_idle", {63'd0, write_enable}, 64'd0);
        check("write_count", 64'(writes_seen), 64'd64);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (is_idle !== 1'b1 || write_enable !== 1'b0 ||
                write_address !== 7'd0 || write_data !== 48'd0) bad++;
        end
        check("idle_hold_100", 64'(bad), 64'd0);
        check("reset_is_idle", {63'd0, is_idle}, 64'd1);
        check("reset_data", {16'd0, write_data}, 64'd0);

        // Gradient, bank 1, with ignored starts and a late y change.
        run_job(3, 1, 0, 'h105, 10, 48'h288C05_280C05, -1, 48'd0, 1'b1, -1);
        // Checkerboard, bank 0.
        run_job(0, 0, 2, 0, 0, 48'h000000_000000, 1, 48'hFFFFFF_FFFFFF, 1'b0, -1);
        // Scrolling bars, followed immediately by a back-to-back job.
        run_job(5, 1, 3, 'h3F0, 0, 48'h000000_000000, 16, 48'hFF0000_FF0000, 1'b0, -1);
        // Gradient at the last row and column, colour wrap.
        run_job(31, 0, 0, 'h3FF, 63, 48'hFCFCFF_FC7CFF, 0, 48'h00FCFF_007CFF, 1'b0, -1);
        // Reset mid-job, then a full solid-white burst.
        run_job(9, 1, 1, 0, -1, 48'd0, -1, 48'd0, 1'b0, 19);
        run_job(10, 1, 1, 0, 5, 48'hFFFFFF_FFFFFF, -1, 48'd0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/line_pattern_writer.md
Name: line_pattern_writer

Overview:
- Writer side of the 64-pixel x 2-bank, 48-bit line buffer. The panel driver is the reader of that buffer.
- On a `start` pulse from the row sequencer, writes one full row pair (upper row y, lower row y+32) of test-pattern pixels into the selected bank, one pixel per cycle.
- Reports completion through `is_idle`, giving the sequencer the same start/is_idle handshake it uses for the driver.

Parameters:
- x_count, 64, pixels per row; must be a power of two; writes per job.
- y_width, 5, width of the y row index; the lower half of the panel is offset by 2**y_width.
- color_width, 8, bits per colour channel.
- address_width, 7, line-buffer address width = log2(x_count) + 1 bank bit.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high.
- start  input  1  job request; sampled only while is_idle=1.
- y  input  y_width  upper-half row index for the job.
- bank  input  1  target buffer half.
- pattern_select  input  2  0=gradient, 1=solid white, 2=checkerboard, 3=scrolling bars.
- frame_count  input  10  current frame number.
- is_idle  output  1  1 when no job is in progress.
- write_address  output  address_width  {bank, x}.
- write_data  output  6*color_width  [47:24] lower pixel, [23:0] upper pixel; each pixel is {r[23:16], g[15:8], b[7:0]}.
- write_enable  output  1  write strobe, one pixel per cycle.

Behaviour:
- Reset values (asynchronous, immediate): is_idle=1, write_enable=0, write_address=0, write_data=0, state=kIdle, x counter=0.
- States:
  - kIdle: is_idle=1. On start=1, latch y, bank, pattern_select and frame_count into job registers, clear x, go to kWrite.
  - kWrite: one pixel index issued per cycle. Pattern is computed combinationally from x and the job registers, then registered into write_address/write_data/write_enable (one pipeline stage). When x=x_count-1 is issued, go to kDrain.
  - kDrain: the final registered write is presented. On the next edge write_enable returns to 0, is_idle returns to 1, and the state returns to kIdle.
- Timing (start sampled high at edge N):
  - is_idle=0 from N+1.
  - First write (x=0) presented in cycle N+2.
  - Writes are contiguous: exactly x_count cycles with write_enable=1, cycles N+2 .. N+1+x_count.
  - is_idle=1 again at N+2+x_count (N+66 at defaults).
- start while is_idle=0 is ignored, not queued. Input changes after the start edge do not affect the job in progress.
- start asserted in the same cycle is_idle rises is accepted, so back-to-back jobs have one idle cycle between write bursts.
- Row values:
  - yu = {1'b0, y}, yl = {1'b1, y}, each y_width+1 bits.
  - All colour arithmetic truncates modulo 2**color_width; no saturation.
- Patterns (shown for the upper pixel; the lower pixel uses yl in place of yu):
  - 0 gradient: r = x<<2, g = yu<<2, b = frame_count[7:0].
  - 1 solid white: r = g = b = all ones.
  - 2 checkerboard: white if x[0]^yu[0] = 1, else black (all zeros). The lower pixel uses yl[0], which equals y[0], so it is the same colour as the upper pixel.
  - 3 scrolling bars: let s = (x + frame_count[5:0]) mod x_count. r = all ones if s[5:4]=0. g = all ones if s[5:4]=1. b = all ones if s[5:4]=2. All channels = 0 if s[5:4]=3.
- Wrap-around: x never exceeds x_count-1. The bank bit never carries into or out of the x field.
- Reset mid-job: write_enable drops on reset assertion, without waiting for a clock. After release the block is in kIdle. The partially written bank content is undefined, and the sequencer restarts the row.

Test Plan:
- Reset released, no start → is_idle=1, write_enable=0, write_address=0, write_data=0 held for 100 cycles.
- start at edge N; y=3, bank=1, pattern=0, frame_count=0x105 → write_enable is 1 for exactly cycles N+2..N+65. Addresses are 0x40..0x7F. At x=10, write_data = upper {0x28,0x0C,0x05}, lower {0x28,0x8C,0x05}. is_idle=1 at N+66.
- start pulsed again at N+5 and N+30 during the above job → ignored: still exactly 64 writes, addresses unchanged. y changed to 7 at N+3 has no effect on the data.
- pattern=2, y=0, bank=0 → x=0 writes 0x000000_000000; x=1 writes 0xFFFFFF_FFFFFF; addresses 0x00..0x3F.
- pattern=3, frame_count=0x3F0 → s = x+0x30 mod 64. x=0 gives s=0x30 → black; x=16 gives s=0 → red 0xFF0000 in both halves.
- reset asserted at N+20 mid-job → write_enable=0 and is_idle=1 immediately. After release, start → a full 64-write burst from x=0.
